// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM states and nibble width for serial_add_seq
package serial_add_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_seq.sv
// serial_add_seq: nibble-serial adder driving an external 4-bit adder, one nibble per cycle
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  input  logic                     cin,
  output logic [NIB_W-1:0]         add_a,
  output logic [NIB_W-1:0]         add_b,
  output logic                     add_cin,
  input  logic [NIB_W-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                     ovf
`endif
);
  localparam int W = NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  state_t state, nxt;
  logic [W-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic carry, last, run, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    run = state == RUN;
    last = idx == IW'(NIBBLES - 1);
    in_ready = state == IDLE;
    accept = in_ready && in_valid;
    out_valid = state == DONE;
    nxt = accept ? RUN : (run && last) ? DONE : (out_valid && out_ready) ? IDLE : state;
    add_a = run ? a_q[idx*NIB_W +: NIB_W] : '0;
    add_b = run ? b_q[idx*NIB_W +: NIB_W] : '0;
    add_cin = run ? carry : 1'b0;
  end
`ifdef SERIAL_ADD_OVF_EN
  // carry into bit 3 of the top nibble, recovered from the adder's own inputs
  logic [3:0] low;
  assign low = {1'b0, add_a[2:0]} + {1'b0, add_b[2:0]} + {3'b0, add_cin};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (run && last) ovf <= add_cout ^ low[3];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      idx <= '0;
      result <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
      carry <= cin;
      idx <= '0;
    end else if (run) begin
      result[idx*NIB_W +: NIB_W] <= add_sum;
      carry <= add_cout;
      idx <= idx + 1'b1;
      if (last) cout <= add_cout;
    end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand; the legal range is 1..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand request.
REQ-006 SHALL have ports op_a and op_b, input, 4*NIBBLES bits: operands, unsigned.
REQ-007 SHALL have port cin, input, 1 bit: carry-in to the least-significant nibble.
REQ-008 SHALL have ports add_a and add_b, output, 4 bits each: nibble operands driven to the external 4-bit adder.
REQ-009 SHALL have port add_cin, output, 1 bit: carry driven to the external adder.
REQ-010 SHALL have ports add_sum (input, 4 bits) and add_cout (input, 1 bit): combinational result of the external adder, sampled in the same cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: result available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result, output, 4*NIBBLES bits: the full sum.
REQ-014 SHALL have port cout, output, 1 bit: final carry-out.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL assert in_ready only in IDLE; a request SHALL be accepted when in_valid and in_ready are both high at a rising edge.
REQ-017 On acceptance, SHALL register op_a, op_b and cin, clear the nibble index to 0, and go to RUN.
REQ-018 In RUN, SHALL drive add_a and add_b from operand nibble [index] and add_cin from the carry register; these outputs SHALL be driven to 0 outside RUN.
REQ-019 At each RUN edge, SHALL write add_sum into result nibble [index], load add_cout into the carry register, and increment the index.
REQ-020 When the index equals NIBBLES-1 at a RUN edge, SHALL capture that nibble, set cout from add_cout, and go to DONE.
REQ-021 Latency SHALL be exactly: acceptance at edge k gives out_valid high from edge k+NIBBLES onward; with NIBBLES=4, four RUN cycles precede DONE.
REQ-022 In DONE, SHALL hold out_valid high, with result and cout stable, until out_ready is high at an edge; it SHALL then go to IDLE.
REQ-023 SHALL NOT allow back-to-back acceptance from DONE; in_ready rises only in the cycle after the result handshake.
REQ-024 in_valid while busy SHALL be ignored, and operand changes after acceptance SHALL NOT affect the result.
REQ-025 The result width SHALL be exactly 4*NIBBLES bits; overflow appears only on cout.
REQ-026 result and cout SHALL retain their last value in IDLE.

Reset
REQ-027 rst_n low SHALL immediately force the state to IDLE and set the index, carry register, result, cout and out_valid to 0; in_ready SHALL be 1 once rst_n is released.
REQ-028 Reset during RUN or DONE SHALL abort the transfer with no output handshake.

Configuration
REQ-029 With SERIAL_ADD_OVF_EN defined, SHALL add output ovf (1 bit), equal to the signed (two's-complement) overflow of the most-significant nibble (add_cout XOR carry into bit 3), registered with cout and reset to 0.
REQ-030 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL be absent.

Structure
REQ-031 The FSM state enumeration and the nibble width constant (4) SHALL reside in a shared package serial_add_pkg.
REQ-032 No sub-module SHALL be used: the adder is external, and a NIBBLES=1 build SHALL be legal with a single RUN cycle.

Verification
REQ-033 Stimulus 0x1234 + 0x4321, cin=0 -> result 0x5555, cout 0, out_valid on the 4th edge after acceptance.
REQ-034 Stimulus 0xFFFF + 0x0001, cin=0 -> result 0x0000, cout 1; the carry propagates through all four nibbles.
REQ-035 Stimulus 0xFFFF + 0xFFFF, cin=1 -> result 0xFFFF, cout 1.
REQ-036 With out_ready held low for 5 cycles and in_valid high throughout -> result stable, in_ready 0; the next acceptance occurs in the cycle after the handshake.
REQ-037 rst_n pulsed low during the 2nd RUN cycle -> out_valid never asserts; all outputs are 0; a following 0x0001 + 0x0001 gives 0x0002.
REQ-038 With SERIAL_ADD_OVF_EN defined, stimulus 0x7FFF + 0x0001 -> result 0x8000, cout 0, ovf 1.
